// File: rtl/fetch_aligner.sv
// Halfword realignment buffer in front of the RVC decoder: turns word-aligned
// fetch words into one 16- or 32-bit instruction per handshake, with its PC.
module fetch_aligner #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [XLEN-1:0] fetch_addr_i,
  input  logic [31:0]     fetch_data_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     instruction_o,
  output logic            is_rv_o,
  output logic [XLEN-1:0] pc_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on the same-side valid.

  logic [15:0]     r_hb0, r_hb1, r_hb2;
  logic [1:0]      r_cnt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_exp_addr;
  logic            r_skip_lo;

  logic            w_is_rv;
  logic            w_valid;
  logic [1:0]      w_sz;
  logic            w_out_fire;
  logic [1:0]      w_cnt_c;
  logic [15:0]     w_s0, w_s1, w_s2;
  logic            w_fetch_ready;
  logic            w_accept;
  logic [15:0]     w_first;
  logic [15:0]     w_n0, w_n1, w_n2;
  logic [1:0]      w_n_cnt;
  logic            w_unused;

  assign w_unused = flush_pc_i[0];

  always_comb begin
    w_is_rv    = (r_hb0[1:0] == 2'b11);
    w_valid    = !rst && !flush_i &&
                 ((r_cnt >= 2'd2) || ((r_cnt == 2'd1) && !w_is_rv));
    w_sz       = w_is_rv ? 2'd2 : 2'd1;
    w_out_fire = w_valid && inst_ready_i;
    w_cnt_c    = r_cnt - (w_out_fire ? w_sz : 2'd0);

    // Post-consume buffer; slots above w_cnt_c are don't-care.
    w_s0 = r_hb0;
    w_s1 = r_hb1;
    w_s2 = r_hb2;
    if (w_out_fire) begin
      if (w_sz == 2'd1) begin
        w_s0 = r_hb1;
        w_s1 = r_hb2;
      end else begin
        w_s0 = r_hb2;
      end
    end

    // A whole word must fit after this cycle's consume, even if skip_lo
    // would only push one halfword.
    w_fetch_ready = !rst && !flush_i && (w_cnt_c <= 2'd1);
    w_accept      = fetch_valid_i && w_fetch_ready && (fetch_addr_i == r_exp_addr);

    w_first = r_skip_lo ? fetch_data_i[31:16] : fetch_data_i[15:0];
    w_n0    = w_s0;
    w_n1    = w_s1;
    w_n2    = w_s2;
    w_n_cnt = w_cnt_c;
    if (w_accept) begin
      w_n_cnt = w_cnt_c + (r_skip_lo ? 2'd1 : 2'd2);
      case (w_cnt_c)
        2'd0: begin
          w_n0 = w_first;
          if (!r_skip_lo) w_n1 = fetch_data_i[31:16];
        end
        2'd1: begin
          w_n1 = w_first;
          if (!r_skip_lo) w_n2 = fetch_data_i[31:16];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 2'd0;
      r_pc       <= '0;
      r_exp_addr <= '0;
      r_skip_lo  <= 1'b0;
    end else if (flush_i) begin
      r_cnt      <= 2'd0;
      r_pc       <= {flush_pc_i[XLEN-1:1], 1'b0};
      r_exp_addr <= {flush_pc_i[XLEN-1:2], 2'b00};
      r_skip_lo  <= flush_pc_i[1];
    end else begin
      r_hb0 <= w_n0;
      r_hb1 <= w_n1;
      r_hb2 <= w_n2;
      r_cnt <= w_n_cnt;
      if (w_out_fire) begin
        r_pc <= r_pc + {{(XLEN-3){1'b0}}, w_sz, 1'b0};
      end
      if (w_accept) begin
        r_exp_addr <= r_exp_addr + {{(XLEN-3){1'b0}}, 3'd4};
        r_skip_lo  <= 1'b0;
      end
    end
  end

  assign fetch_ready_o = w_fetch_ready;
  assign inst_valid_o  = w_valid;
  assign is_rv_o       = w_valid && w_is_rv;
  assign instruction_o = !w_valid ? 32'h0 :
                         (w_is_rv ? {r_hb1, r_hb0} : {16'h0, r_hb0});
  assign pc_o          = r_pc;

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner: expected instructions are queued by the
// stimulus and checked by an independent output monitor.
module tb_fetch_aligner;

  localparam int XLEN = 64;
  localparam int W    = XLEN + 32 + 1;

  logic            clk;
  logic            rst;
  logic            flush_i;
  logic [XLEN-1:0] flush_pc_i;
  logic            fetch_valid_i;
  logic            fetch_ready_o;
  logic [XLEN-1:0] fetch_addr_i;
  logic [31:0]     fetch_data_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [31:0]     instruction_o;
  logic            is_rv_o;
  logic [XLEN-1:0] pc_o;

  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  fetch_aligner #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_addr_i  (fetch_addr_i),
    .fetch_data_i  (fetch_data_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .instruction_o (instruction_o),
    .is_rv_o       (is_rv_o),
    .pc_o          (pc_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && inst_valid_o && inst_ready_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_inst: got pc=%h inst=%h rv=%0d, required none",
                 pc_o, instruction_o, is_rv_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({pc_o, instruction_o, is_rv_o} !== e) begin
          n_fail++;
          $display("FAIL inst_out: got pc=%h inst=%h rv=%0d, required pc=%h inst=%h rv=%0d",
                   pc_o, instruction_o, is_rv_o, e[W-1:33], e[32:1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_inst(input logic [XLEN-1:0] pc, input logic [31:0] inst, input logic rv);
    exp_q.push_back({pc, inst, rv});
  endtask

  // driver tasks; all start and end just after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [XLEN-1:0] pc);
    flush_i    = 1'b1;
    flush_pc_i = pc;
    tick();
    flush_i    = 1'b0;
  endtask

  task automatic send_word(input logic [XLEN-1:0] a, input logic [31:0] d);
    int t;
    fetch_valid_i = 1'b1;
    fetch_addr_i  = a;
    fetch_data_i  = d;
    t = 0;
    @(negedge clk);
    while (!fetch_ready_o && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!fetch_ready_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got fetch_ready_o=0 for addr %h, required 1", a);
    end
    tick();
    fetch_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      t++;
      tick();
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; flush_pc_i = '0;
    fetch_valid_i = 1'b0; fetch_addr_i = '0; fetch_data_i = '0; inst_ready_i = 1'b0;

    // reset
    tick();
    @(negedge clk);
    chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready_o), 64'd0);
    chk("rst_instruction", 64'(instruction_o), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_pc", pc_o, 64'd0);
    chk("post_rst_valid", 64'(inst_valid_o), 64'd0);
    tick();

    // two 32-bit instructions, back to back
    inst_ready_i = 1'b1;
    do_flush(64'h1000);
    expect_inst(64'h1000, 32'h00B50533, 1'b1);
    expect_inst(64'h1004, 32'h00000513, 1'b1);
    send_word(64'h1000, 32'h00B50533);
    send_word(64'h1004, 32'h00000513);
    drain();

    // two compressed in one word
    do_flush(64'h2000);
    expect_inst(64'h2000, 32'h00004501, 1'b0);
    expect_inst(64'h2002, 32'h00004581, 1'b0);
    send_word(64'h2000, 32'h45814501);
    drain();

    // 32-bit instruction straddling two words
    do_flush(64'h3000);
    expect_inst(64'h3000, 32'h00004501, 1'b0);
    expect_inst(64'h3002, 32'h00000513, 1'b1);
    send_word(64'h3000, 32'h05134501);
    tick();
    @(negedge clk);
    chk("straddle_wait_valid", 64'(inst_valid_o), 64'd0);
    tick();
    send_word(64'h3004, 32'h00030000);
    drain();
    tick();
    @(negedge clk);
    chk("partial_tail_valid", 64'(inst_valid_o), 64'd0);
    chk("partial_tail_pc", pc_o, 64'h3006);
    tick();

    // halfword-aligned redirect with stale words around it
    do_flush(64'h4002);
    send_word(64'h3008, 32'h45014501);
    @(negedge clk);
    chk("stale_drop_valid", 64'(inst_valid_o), 64'd0);
    chk("flush_half_pc", pc_o, 64'h4002);
    tick();
    expect_inst(64'h4002, 32'h00004505, 1'b0);
    send_word(64'h4000, 32'h4505FFFF);
    drain();
    send_word(64'h3008, 32'h45014501);
    @(negedge clk);
    chk("stale_drop2_valid", 64'(inst_valid_o), 64'd0);
    chk("stale_drop2_pc", pc_o, 64'h4004);
    tick();

    // address wrap
    do_flush(64'hFFFF_FFFF_FFFF_FFFC);
    expect_inst(64'hFFFF_FFFF_FFFF_FFFC, 32'h00004501, 1'b0);
    expect_inst(64'hFFFF_FFFF_FFFF_FFFE, 32'h00004581, 1'b0);
    expect_inst(64'h0, 32'h00004511, 1'b0);
    expect_inst(64'h2, 32'h00000000, 1'b0);
    send_word(64'hFFFF_FFFF_FFFF_FFFC, 32'h45814501);
    send_word(64'h0, 32'h00004511);
    drain();

    // backpressure with three compressed halfwords buffered
    inst_ready_i = 1'b0;
    do_flush(64'h5002);
    send_word(64'h5000, 32'h4501FFFF);
    send_word(64'h5004, 32'h45814511);
    @(negedge clk);
    chk("full_fetch_ready", 64'(fetch_ready_o), 64'd0);
    chk("full_inst_valid", 64'(inst_valid_o), 64'd1);
    tick();
    expect_inst(64'h5002, 32'h00004501, 1'b0);
    inst_ready_i = 1'b1;
    @(negedge clk);
    chk("c_consume_fetch_ready", 64'(fetch_ready_o), 64'd0);
    tick();
    inst_ready_i = 1'b0;
    @(negedge clk);
    chk("after_c_fetch_ready", 64'(fetch_ready_o), 64'd0);
    chk("after_c_pc", pc_o, 64'h5004);
    tick();
    expect_inst(64'h5004, 32'h00004511, 1'b0);
    expect_inst(64'h5006, 32'h00004581, 1'b0);
    inst_ready_i = 1'b1;
    drain();

    // flush in the same cycle as attempted accept and consume
    inst_ready_i = 1'b0;
    do_flush(64'h6000);
    send_word(64'h6000, 32'h45014501);
    flush_i = 1'b1; flush_pc_i = 64'h7002;
    fetch_valid_i = 1'b1; fetch_addr_i = 64'h6004; fetch_data_i = 32'h45114511;
    inst_ready_i = 1'b1;
    @(negedge clk);
    chk("flush_cyc_valid", 64'(inst_valid_o), 64'd0);
    chk("flush_cyc_fetch_ready", 64'(fetch_ready_o), 64'd0);
    tick();
    flush_i = 1'b0; fetch_valid_i = 1'b0; inst_ready_i = 1'b0;
    @(negedge clk);
    chk("post_flush_valid", 64'(inst_valid_o), 64'd0);
    chk("post_flush_pc", pc_o, 64'h7002);
    tick();
    expect_inst(64'h7002, 32'h00004531, 1'b0);
    inst_ready_i = 1'b1;
    send_word(64'h7000, 32'h4531FFFF);
    drain();

    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
